// File: rtl/pagerank_pkg.sv
// Shared definitions for the pageRank graph front end: FSM encoding,
// degree-width helper and the Q0.WIDTH saturation constant.
package pagerank_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COUNT = 3'd2,
    S_DIV   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Width able to hold an out-degree in 0..n
  function automatic int deg_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // All-ones Q0.w value, the closest representable weight to 1.0
  function automatic logic [63:0] q_sat(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/pagerank_recip_div.sv
// Sequential restoring divide of 2^WIDTH by deg; first of WIDTH+1 iterations
// runs on the go edge, done pulses once the quotient is final.
module pagerank_recip_div #(
  parameter int WIDTH = 16,
  parameter int DW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [DW-1:0]    deg,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);
  import pagerank_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] Q_SAT = WIDTH'(q_sat(WIDTH));

  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_deg;
  logic [DW-1:0] r_rem;
  logic [WIDTH:0] r_quo;
  logic [CW-1:0] r_cnt;

  logic [DW-1:0] w_rem_in;
  logic [DW-1:0] w_dvs;
  logic [DW:0]   w_shift;
  logic [DW:0]   w_diff;
  logic          w_ge;

  // Dividend is a single 1 followed by WIDTH zeros, so only the go step shifts in a 1
  assign w_rem_in = go ? '0 : r_rem;
  assign w_dvs    = go ? deg : r_deg;
  assign w_shift  = {w_rem_in, go};
  assign w_ge     = (w_shift >= {1'b0, w_dvs});
  assign w_diff   = w_shift - {1'b0, w_dvs};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_deg  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (go || r_busy) begin
        r_rem <= w_ge ? w_diff[DW-1:0] : w_shift[DW-1:0];
        r_quo <= {(go ? WIDTH'(0) : r_quo[WIDTH-1:0]), w_ge};
      end
      if (go) begin
        r_deg  <= deg;
        r_cnt  <= CW'(WIDTH);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  // Quotient bit WIDTH is set only for deg=1 (exactly 2^WIDTH) or deg=0
  assign q    = (r_deg == '0) ? '0 : (r_quo[WIDTH] ? Q_SAT : r_quo[WIDTH-1:0]);
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: rtl/pagerank_graph_loader.sv
// Loads a serial edge stream into an N*N adjacency matrix, then derives
// per-node 1/out-degree weights in Q0.WIDTH; results held while graph_valid.
module pagerank_graph_loader #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int IDX_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               edge_valid,
  output logic               edge_ready,
  input  logic [IDX_W-1:0]   edge_src,
  input  logic [IDX_W-1:0]   edge_dst,
  input  logic               edge_last,
  output logic [N*N-1:0]     adj,
  output logic [N*WIDTH-1:0] nodeWeight,
  output logic               busy,
  output logic               graph_valid,
  output logic               err_range
);
  import pagerank_pkg::*;

  localparam int DW = deg_width(N);
  localparam logic [N*N-1:0] ADJ_ONE = (N*N)'(1);

  state_t             r_state;
  logic [N*N-1:0]     r_adj;
  logic [N*WIDTH-1:0] r_wgt;
  logic [IDX_W-1:0]   r_j;
  logic               r_ready;
  logic               r_busy;
  logic               r_gv;
  logic               r_err;

  logic               w_accept;
  logic               w_in_range;
  logic [N*N-1:0]     w_mask;
  logic [N*N-1:0]     w_col;
  logic [DW-1:0]      w_deg;
  logic               w_go;
  logic               w_div_busy;
  logic               w_div_done;
  logic [WIDTH-1:0]   w_q;
  logic [N*WIDTH-1:0] w_q_ext;

  assign w_accept   = edge_valid && r_ready;
  assign w_in_range = (int'(edge_src) < N) && (int'(edge_dst) < N);
  assign w_mask     = ADJ_ONE << (int'(edge_dst) * N + int'(edge_src));

  // Column j holds the out-edges of node j; shift it down to bit positions i*N
  assign w_col = r_adj >> r_j;
  always_comb begin
    w_deg = '0;
    for (int i = 0; i < N; i++) w_deg = w_deg + DW'(w_col[i*N]);
  end

  assign w_go    = (r_state == S_COUNT) && !w_div_busy;
  assign w_q_ext = (N*WIDTH)'(w_q) << (int'(r_j) * WIDTH);

  pagerank_recip_div #(.WIDTH(WIDTH), .DW(DW)) u_div (
    .clk   (clk),
    .reset (reset),
    .go    (w_go),
    .deg   (w_deg),
    .busy  (w_div_busy),
    .done  (w_div_done),
    .q     (w_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_adj   <= '0;
      r_wgt   <= '0;
      r_j     <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_gv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_adj   <= '0;
            r_wgt   <= '0;
            r_err   <= 1'b0;
            r_gv    <= 1'b0;
            r_j     <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (w_in_range) r_adj <= r_adj | w_mask;
            else            r_err <= 1'b1;
            if (edge_last) begin
              r_state <= S_COUNT;
              r_ready <= 1'b0;
            end
          end
        end
        S_COUNT: begin
          if (w_go) r_state <= S_DIV;
        end
        S_DIV: begin
          // Slots were cleared on start and each is written once, so OR is enough
          if (w_div_done) begin
            r_wgt <= r_wgt | w_q_ext;
            if (r_j == IDX_W'(N-1)) begin
              r_state <= S_DONE;
              r_gv    <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_j     <= r_j + 1'b1;
              r_state <= S_COUNT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign adj         = r_adj;
  assign nodeWeight  = r_wgt;
  assign edge_ready  = r_ready;
  assign busy        = r_busy;
  assign graph_valid = r_gv;
  assign err_range   = r_err;

endmodule

// File: tb/tb_pagerank_graph_loader.sv
// Bench for pagerank_graph_loader: directed scenarios plus random graphs
// compared against an adjacency/out-degree reference model.
module tb_pagerank_graph_loader;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;
  localparam int LAT = N * (W + 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, start, edge_valid, edge_last, edge_ready;
  logic [IW-1:0]  edge_src, edge_dst;
  logic [N*N-1:0] adj;
  logic [N*W-1:0] nodeWeight;
  logic           busy, graph_valid, err_range;

  logic           start3, edge_valid3, edge_last3, edge_ready3;
  logic [1:0]     edge_src3, edge_dst3;
  logic [8:0]     adj3;
  logic [47:0]    nw3;
  logic           busy3, gv3, err3;

  pagerank_graph_loader #(.N(N), .WIDTH(W), .IDX_W(IW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .edge_valid(edge_valid),
    .edge_ready(edge_ready), .edge_src(edge_src), .edge_dst(edge_dst),
    .edge_last(edge_last), .adj(adj), .nodeWeight(nodeWeight), .busy(busy),
    .graph_valid(graph_valid), .err_range(err_range)
  );

  pagerank_graph_loader #(.N(3), .WIDTH(W), .IDX_W(2)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .edge_valid(edge_valid3),
    .edge_ready(edge_ready3), .edge_src(edge_src3), .edge_dst(edge_dst3),
    .edge_last(edge_last3), .adj(adj3), .nodeWeight(nw3), .busy(busy3),
    .graph_valid(gv3), .err_range(err3)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int q_src[$];
  int q_dst[$];
  logic [N*N-1:0] exp_adj;
  logic [N*W-1:0] exp_nw;
  int ready_low;

  // Reference: adjacency from the edge set, weight from counted out-degree
  function automatic void model();
    bit a[N][N];
    int deg;
    int w;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) a[i][j] = 0;
    for (int k = 0; k < q_src.size(); k++) a[q_dst[k]][q_src[k]] = 1;
    exp_adj = '0;
    exp_nw  = '0;
    for (int j = 0; j < N; j++) begin
      deg = 0;
      for (int i = 0; i < N; i++) begin
        deg += int'(a[i][j]);
        exp_adj[i*N+j] = a[i][j];
      end
      w = (deg == 0) ? 0 : (deg == 1) ? 65535 : 65536 / deg;
      exp_nw[j*W +: W] = W'(w);
    end
  endfunction

  task automatic load_t1();
    q_src = '{2, 3, 0, 0, 1, 3, 0, 1};
    q_dst = '{0, 0, 1, 2, 2, 2, 3, 3};
  endtask

  task automatic start_pulse();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_all(input bit gapped, input bit mark_last, output int acc);
    int t;
    acc = 0;
    for (int k = 0; k < q_src.size(); k++) begin
      if (gapped) repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        if (edge_ready !== 1'b1) ready_low++;
      end
      @(negedge clk);
      edge_valid = 1'b1;
      edge_src   = IW'(q_src[k]);
      edge_dst   = IW'(q_dst[k]);
      edge_last  = mark_last && (k == q_src.size() - 1);
      t = 0;
      while (edge_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (t >= 50) begin
        $display("FAIL edge_accept_timeout: edge_ready=%b required 1", edge_ready);
        errors++;
      end
      @(posedge clk); #1;
      acc = cyc;
      edge_valid = 1'b0;
      edge_last  = 1'b0;
    end
  endtask

  task automatic wait_gv(input int acc, output int lat);
    int t = 0;
    while (graph_valid !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    lat = (graph_valid === 1'b1) ? cyc - acc : -1;
  endtask

  task automatic run_graph(input bit gapped, output int lat);
    int acc;
    start_pulse();
    send_all(gapped, 1'b1, acc);
    wait_gv(acc, lat);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; edge_valid = 1'b0; edge_last = 1'b0;
    edge_src = '0; edge_dst = '0;
    start3 = 1'b0; edge_valid3 = 1'b0; edge_last3 = 1'b0;
    edge_src3 = '0; edge_dst3 = '0;
    #12;
    checks++;
    if ({adj, nodeWeight} !== '0) begin
      $display("FAIL reset_buses: adj=%h nw=%h required 0", adj, nodeWeight); errors++;
    end
    checks++;
    if ({edge_ready, busy, graph_valid, err_range} !== 4'b0) begin
      $display("FAIL reset_flags: rdy/busy/gv/err=%b required 0000",
               {edge_ready, busy, graph_valid, err_range}); errors++;
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    load_t1();
    start_pulse();
    checks++;
    if ({busy, edge_ready, graph_valid} !== 3'b110) begin
      $display("FAIL load_entry: busy/rdy/gv=%b required 110", {busy, edge_ready, graph_valid}); errors++;
    end
    begin
      int acc;
      send_all(1'b0, 1'b1, acc);
      wait_gv(acc, lat);
    end
    checks++;
    if (lat !== LAT) begin $display("FAIL basic_latency: got %0d required %0d", lat, LAT); errors++; end
    checks++;
    if (adj !== 16'h3B1C) begin $display("FAIL basic_adj: got %h required 3b1c", adj); errors++; end
    checks++;
    if (nodeWeight !== 64'h8000_FFFF_8000_5555) begin
      $display("FAIL basic_weights: got %h required 8000ffff80005555", nodeWeight); errors++;
    end
    checks++;
    if ({err_range, busy} !== 2'b00) begin
      $display("FAIL basic_flags: err/busy=%b required 00", {err_range, busy}); errors++;
    end
  endtask

  task automatic test_dup_gapped();
    int lat;
    q_src = '{2, 3, 0, 0, 0, 0, 1, 3, 0, 1};
    q_dst = '{0, 0, 1, 2, 2, 2, 2, 2, 3, 3};
    ready_low = 0;
    run_graph(1'b1, lat);
    checks++;
    if (adj !== 16'h3B1C) begin $display("FAIL dup_adj: got %h required 3b1c", adj); errors++; end
    checks++;
    if (nodeWeight !== 64'h8000_FFFF_8000_5555) begin
      $display("FAIL dup_weights: got %h required 8000ffff80005555", nodeWeight); errors++;
    end
    checks++;
    if (ready_low !== 0) begin $display("FAIL dup_ready_low: got %0d cycles required 0", ready_low); errors++; end
  endtask

  task automatic test_self_loop();
    int lat;
    q_src = '{1};
    q_dst = '{1};
    run_graph(1'b0, lat);
    checks++;
    if (adj !== 16'h0020) begin $display("FAIL self_adj: got %h required 0020", adj); errors++; end
    checks++;
    if (nodeWeight !== 64'h0000_0000_FFFF_0000) begin
      $display("FAIL self_weights: got %h required 00000000ffff0000", nodeWeight); errors++;
    end
  endtask

  task automatic send3(input int s, input int d, input bit last);
    int t = 0;
    @(negedge clk);
    edge_valid3 = 1'b1; edge_src3 = 2'(s); edge_dst3 = 2'(d); edge_last3 = last;
    while (edge_ready3 !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (t >= 20) begin $display("FAIL n3_accept_timeout: edge_ready=%b required 1", edge_ready3); errors++; end
    @(posedge clk); #1;
    edge_valid3 = 1'b0; edge_last3 = 1'b0;
  endtask

  task automatic wait_gv3();
    int t = 0;
    while (gv3 !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    checks++;
    if (gv3 !== 1'b1) begin $display("FAIL n3_gv_timeout: gv=%b required 1", gv3); errors++; end
  endtask

  task automatic test_range();
    @(negedge clk); start3 = 1'b1; @(negedge clk); start3 = 1'b0;
    send3(0, 1, 1'b0);
    send3(3, 0, 1'b0);
    checks++;
    if (err3 !== 1'b1) begin $display("FAIL range_err_set: got %b required 1", err3); errors++; end
    send3(2, 2, 1'b1);
    wait_gv3();
    checks++;
    if (adj3 !== 9'h108) begin $display("FAIL range_adj: got %h required 108", adj3); errors++; end
    checks++;
    if (nw3 !== 48'hFFFF_0000_FFFF) begin $display("FAIL range_weights: got %h required ffff0000ffff", nw3); errors++; end
    checks++;
    if (err3 !== 1'b1) begin $display("FAIL range_err_sticky: got %b required 1", err3); errors++; end
    @(negedge clk); start3 = 1'b1; @(negedge clk); start3 = 1'b0;
    checks++;
    if ({err3, gv3} !== 2'b00) begin $display("FAIL range_clear: err/gv=%b required 00", {err3, gv3}); errors++; end
    send3(1, 3, 1'b1);
    wait_gv3();
    checks++;
    if ({err3, adj3, nw3} !== {1'b1, 9'h0, 48'h0}) begin
      $display("FAIL range_last_oor: err=%b adj=%h nw=%h required 1/000/0", err3, adj3, nw3); errors++;
    end
  endtask

  task automatic test_start_ignored_and_reset();
    int acc, lat;
    q_src = '{2, 3, 0, 0};
    q_dst = '{0, 0, 1, 2};
    start_pulse();
    send_all(1'b0, 1'b0, acc);
    start_pulse();
    checks++;
    if (adj !== 16'h011C) begin $display("FAIL midload_start_adj: got %h required 011c", adj); errors++; end
    q_src = '{1, 3, 0, 1};
    q_dst = '{2, 2, 3, 3};
    send_all(1'b0, 1'b1, acc);
    wait_gv(acc, lat);
    checks++;
    if (adj !== 16'h3B1C || nodeWeight !== 64'h8000_FFFF_8000_5555) begin
      $display("FAIL midload_result: adj=%h nw=%h required 3b1c/8000ffff80005555", adj, nodeWeight); errors++;
    end
    load_t1();
    start_pulse();
    send_all(1'b0, 1'b1, acc);
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin $display("FAIL pre_reset_busy: got %b required 1", busy); errors++; end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({adj, nodeWeight, edge_ready, busy, graph_valid, err_range} !== '0) begin
      $display("FAIL async_reset: adj=%h nw=%h flags=%b required all 0", adj, nodeWeight,
               {edge_ready, busy, graph_valid, err_range}); errors++;
    end
    @(negedge clk); reset = 1'b1;
    run_graph(1'b0, lat);
    checks++;
    if (lat !== LAT || adj !== 16'h3B1C || nodeWeight !== 64'h8000_FFFF_8000_5555) begin
      $display("FAIL rebuild: lat=%0d adj=%h nw=%h required %0d/3b1c/8000ffff80005555",
               lat, adj, nodeWeight, LAT); errors++;
    end
  endtask

  task automatic test_done_hold();
    int rdy_seen = 0;
    @(negedge clk);
    edge_valid = 1'b1; edge_src = 2'd0; edge_dst = 2'd0; edge_last = 1'b1;
    repeat (6) begin @(negedge clk); if (edge_ready !== 1'b0) rdy_seen++; end
    checks++;
    if (rdy_seen !== 0) begin $display("FAIL done_ready: high %0d cycles required 0", rdy_seen); errors++; end
    checks++;
    if (adj !== 16'h3B1C || graph_valid !== 1'b1) begin
      $display("FAIL done_hold: adj=%h gv=%b required 3b1c/1", adj, graph_valid); errors++;
    end
    edge_valid = 1'b0; edge_last = 1'b0;
    start_pulse();
    checks++;
    if ({graph_valid, adj} !== {1'b0, 16'h0}) begin
      $display("FAIL done_restart: gv=%b adj=%h required 0/0000", graph_valid, adj); errors++;
    end
    q_src = '{0};
    q_dst = '{0};
    begin
      int acc, lat;
      send_all(1'b0, 1'b1, acc);
      wait_gv(acc, lat);
    end
  endtask

  task automatic test_random();
    int lat, n;
    for (int it = 0; it < 6; it++) begin
      q_src.delete();
      q_dst.delete();
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        q_src.push_back($urandom_range(0, N-1));
        q_dst.push_back($urandom_range(0, N-1));
      end
      model();
      run_graph(1'b1, lat);
      checks++;
      if (lat !== LAT) begin $display("FAIL rand%0d_latency: got %0d required %0d", it, lat, LAT); errors++; end
      checks++;
      if (adj !== exp_adj) begin $display("FAIL rand%0d_adj: got %h required %h", it, adj, exp_adj); errors++; end
      checks++;
      if (nodeWeight !== exp_nw) begin
        $display("FAIL rand%0d_weights: got %h required %h", it, nodeWeight, exp_nw); errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dup_gapped();
    test_self_loop();
    test_range();
    test_start_ignored_and_reset();
    test_done_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
